// File: rtl/i2c_wb_seq_pkg.sv
// Shared constants and types for the IICMB Wishbone command sequencer.
// The optional build macro I2C_WB_SEQ_POLL_EN is consumed by i2c_wb_sequencer.
package i2c_wb_seq_pkg;

  // IICMB register map
  localparam logic [1:0] RegCsr  = 2'd0;
  localparam logic [1:0] RegDpr  = 2'd1;
  localparam logic [1:0] RegCmdr = 2'd2;

  // CMDR command codes (upper bits of a command write are zero)
  typedef enum logic [2:0] {
    CmdWrite   = 3'b001,
    CmdReadAck = 3'b010,
    CmdReadNak = 3'b011,
    CmdStart   = 3'b100,
    CmdStop    = 3'b101,
    CmdSetBus  = 3'b110
  } i2c_cmd_t;

  // Completion status reported with done_o
  typedef enum logic [1:0] {
    ErrOk      = 2'd0,
    ErrNak     = 2'd1,
    ErrArbLost = 2'd2,
    ErrBadBus  = 2'd3
  } seq_err_t;

  // CMDR status bit positions
  localparam int unsigned StatDon = 7;
  localparam int unsigned StatNak = 6;
  localparam int unsigned StatAl  = 5;
  localparam int unsigned StatErr = 4;

  // Sequencer FSM states
  localparam logic [3:0] StInit      = 4'd0;
  localparam logic [3:0] StIdle      = 4'd1;
  localparam logic [3:0] StSetBusDpr = 4'd2;
  localparam logic [3:0] StSetBusCmd = 4'd3;
  localparam logic [3:0] StStartCmd  = 4'd4;
  localparam logic [3:0] StAddrDpr   = 4'd5;
  localparam logic [3:0] StAddrCmd   = 4'd6;
  localparam logic [3:0] StWrData    = 4'd7;
  localparam logic [3:0] StWrCmd     = 4'd8;
  localparam logic [3:0] StRdCmd     = 4'd9;
  localparam logic [3:0] StRdData    = 4'd10;
  localparam logic [3:0] StStopCmd   = 4'd11;
  localparam logic [3:0] StWait      = 4'd12;
  localparam logic [3:0] StStatus    = 4'd13;
  localparam logic [3:0] StGap       = 4'd14;
  localparam logic [3:0] StDone      = 4'd15;

endpackage

// File: rtl/i2c_wb_sequencer_xfer.sv
// Single Wishbone classic access: latch the request, hold cyc/stb until ack,
// drop them the following cycle and pulse done with the captured read data.
module wb_xfer_engine #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] wdat_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] rdat_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i
);

  logic          cyc_q, done_q, we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q, rdat_q;

  // Bus cycle state: open on start, close on ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q  <= 1'b0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (ack_i) begin
          cyc_q  <= 1'b0;
          done_q <= 1'b1;
          rdat_q <= dat_i;
        end
      end else if (start_i) begin
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= wdat_i;
      end
    end
  end

  assign busy_o = cyc_q;
  assign done_o = done_q;
  assign rdat_o = rdat_q;
  assign cyc_o  = cyc_q;
  assign stb_o  = cyc_q;
  assign we_o   = we_q;
  assign adr_o  = adr_q;
  assign dat_o  = dat_q;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Hardware sequencer turning one I2C request into IICMB register traffic.
// Build option: define I2C_WB_SEQ_POLL_EN to poll CMDR instead of waiting on irq_i.
module i2c_wb_sequencer
  import i2c_wb_seq_pkg::*;
#(
  parameter int unsigned NUM_I2C_BUSSES = 1,
  parameter int unsigned BUS_ID_WIDTH   = 4,
  parameter int unsigned I2C_ADDR_WIDTH = 7,
  parameter int unsigned WB_ADDR_WIDTH  = 2,
  parameter int unsigned WB_DATA_WIDTH  = 8,
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned LEN_WIDTH      = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [BUS_ID_WIDTH-1:0]   req_bus_i,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_rd_i,
  input  logic [LEN_WIDTH-1:0]      req_len_i,
  input  logic                      wdata_valid_i,
  output logic                      wdata_ready_o,
  input  logic [WB_DATA_WIDTH-1:0]  wdata_i,
  output logic                      rdata_valid_o,
  output logic [WB_DATA_WIDTH-1:0]  rdata_o,
  output logic                      done_o,
  output logic [1:0]                err_o,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

`ifdef I2C_WB_SEQ_POLL_EN
  localparam logic [7:0] CsrInit = 8'h80;
  logic unused_irq;
  assign unused_irq = irq_i;
`else
  localparam logic [7:0] CsrInit = 8'hC0;
`endif

  logic [3:0]                state_q, state_d, ret_q, ret_d;
  logic [BUS_ID_WIDTH-1:0]   bus_q, bus_d;
  logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      rd_q, rd_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d, cnt_q, cnt_d;
  seq_err_t                  err_q, err_d;
  logic [WB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                      rdata_valid_q, rdata_valid_d;
  logic                      gap_q, gap_d;

  logic                      xfer_start, xfer_we, xfer_busy, xfer_done, go, last;
  logic [WB_ADDR_WIDTH-1:0]  xfer_adr;
  logic [WB_DATA_WIDTH-1:0]  xfer_wdat, xfer_rdat;

  // A new access may only start once the previous one has fully retired
  assign go   = !xfer_busy && !xfer_done;
  assign last = (cnt_q == len_q - LEN_WIDTH'(1));

  // Next-state and Wishbone access request decode
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    bus_d         = bus_q;
    addr_d        = addr_q;
    rd_d          = rd_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    gap_d         = gap_q;
    xfer_start    = 1'b0;
    xfer_we       = 1'b1;
    xfer_adr      = WB_ADDR_WIDTH'(RegCmdr);
    xfer_wdat     = '0;
    wdata_ready_o = 1'b0;
    unique case (state_q)
      StInit: begin
        xfer_start = go;
        xfer_adr   = WB_ADDR_WIDTH'(RegCsr);
        xfer_wdat  = WB_DATA_WIDTH'(CsrInit);
        if (xfer_done) state_d = StIdle;
      end
      StIdle: begin
        if (req_valid_i) begin
          bus_d  = req_bus_i;
          addr_d = req_addr_i;
          rd_d   = req_rd_i;
          len_d  = (32'(req_len_i) > MAX_LEN) ? LEN_WIDTH'(MAX_LEN) : req_len_i;
          cnt_d  = '0;
          err_d  = ErrOk;
          if (32'(req_bus_i) >= NUM_I2C_BUSSES) begin
            err_d   = ErrBadBus;
            state_d = StDone;
          end else begin
            state_d = StSetBusDpr;
          end
        end
      end
      StSetBusDpr: begin
        xfer_start = go;
        xfer_adr   = WB_ADDR_WIDTH'(RegDpr);
        xfer_wdat  = WB_DATA_WIDTH'(bus_q);
        if (xfer_done) state_d = StSetBusCmd;
      end
      StSetBusCmd: begin
        xfer_start = go;
        xfer_wdat  = WB_DATA_WIDTH'(CmdSetBus);
        if (xfer_done) begin
          state_d = StWait;
          ret_d   = StStartCmd;
        end
      end
      StStartCmd: begin
        xfer_start = go;
        xfer_wdat  = WB_DATA_WIDTH'(CmdStart);
        if (xfer_done) begin
          state_d = StWait;
          ret_d   = StAddrDpr;
        end
      end
      StAddrDpr: begin
        xfer_start = go;
        xfer_adr   = WB_ADDR_WIDTH'(RegDpr);
        xfer_wdat  = WB_DATA_WIDTH'({addr_q, rd_q});
        if (xfer_done) state_d = StAddrCmd;
      end
      StAddrCmd: begin
        xfer_start = go;
        xfer_wdat  = WB_DATA_WIDTH'(CmdWrite);
        if (xfer_done) begin
          state_d = StWait;
          ret_d   = (len_q == '0) ? StStopCmd : (rd_q ? StRdCmd : StWrData);
        end
      end
      StWrData: begin
        xfer_start    = go && wdata_valid_i;
        wdata_ready_o = xfer_start;
        xfer_adr      = WB_ADDR_WIDTH'(RegDpr);
        xfer_wdat     = wdata_i;
        if (xfer_done) state_d = StWrCmd;
      end
      StWrCmd: begin
        xfer_start = go;
        xfer_wdat  = WB_DATA_WIDTH'(CmdWrite);
        if (xfer_done) begin
          state_d = StWait;
          ret_d   = last ? StStopCmd : StWrData;
          cnt_d   = cnt_q + LEN_WIDTH'(1);
        end
      end
      StRdCmd: begin
        xfer_start = go;
        xfer_wdat  = last ? WB_DATA_WIDTH'(CmdReadNak) : WB_DATA_WIDTH'(CmdReadAck);
        if (xfer_done) begin
          state_d = StWait;
          ret_d   = StRdData;
        end
      end
      StRdData: begin
        xfer_start = go;
        xfer_we    = 1'b0;
        xfer_adr   = WB_ADDR_WIDTH'(RegDpr);
        if (xfer_done) begin
          rdata_d       = xfer_rdat;
          rdata_valid_d = 1'b1;
          cnt_d         = cnt_q + LEN_WIDTH'(1);
          state_d       = last ? StStopCmd : StRdCmd;
        end
      end
      StStopCmd: begin
        xfer_start = go;
        xfer_wdat  = WB_DATA_WIDTH'(CmdStop);
        if (xfer_done) begin
          state_d = StWait;
          ret_d   = StDone;
        end
      end
      StWait: begin
`ifdef I2C_WB_SEQ_POLL_EN
        state_d = StStatus;
`else
        if (irq_i) state_d = StStatus;
`endif
      end
      StStatus: begin
        xfer_start = go;
        xfer_we    = 1'b0;
        if (xfer_done) begin
          if (xfer_rdat[StatDon]) begin
            state_d = ret_q;
          end else if (xfer_rdat[StatNak]) begin
            // A NAK while already stopping must not loop back into STOP
            if (ret_q != StDone) err_d = ErrNak;
            state_d = (ret_q == StDone) ? StDone : StStopCmd;
          end else if (xfer_rdat[StatAl] || xfer_rdat[StatErr]) begin
            err_d   = ErrArbLost;
            state_d = StDone;
          end else begin
`ifdef I2C_WB_SEQ_POLL_EN
            gap_d   = 1'b0;
            state_d = StGap;
`else
            state_d = StWait;
`endif
          end
        end
      end
      StGap: begin
        // Two idle cycles between status polls
        gap_d = 1'b1;
        if (gap_q) state_d = StStatus;
      end
      StDone: state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StInit;
      ret_q         <= StIdle;
      bus_q         <= '0;
      addr_q        <= '0;
      rd_q          <= 1'b0;
      len_q         <= '0;
      cnt_q         <= '0;
      err_q         <= ErrOk;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      gap_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      bus_q         <= bus_d;
      addr_q        <= addr_d;
      rd_q          <= rd_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      gap_q         <= gap_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign done_o        = (state_q == StDone);
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;

  wb_xfer_engine #(
    .AW(WB_ADDR_WIDTH),
    .DW(WB_DATA_WIDTH)
  ) u_xfer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(xfer_start),
    .we_i   (xfer_we),
    .adr_i  (xfer_adr),
    .wdat_i (xfer_wdat),
    .busy_o (xfer_busy),
    .done_o (xfer_done),
    .rdat_o (xfer_rdat),
    .cyc_o  (cyc_o),
    .stb_o  (stb_o),
    .we_o   (we_o),
    .adr_o  (adr_o),
    .dat_o  (dat_o),
    .dat_i  (dat_i),
    .ack_i  (ack_i)
  );

endmodule

// File: doc/i2c_wb_sequencer.md
Name: i2c_wb_sequencer

Overview:
- Synthesizable Wishbone master that drives the IICMB I2C controller (iicmb_m_wb) through its CSR/DPR/CMDR/FSMR registers.
- Turns one request (bus, 7-bit slave address, direction, length) into the complete command sequence: set-bus, start, address, N data bytes, stop.
- Sits between a request/stream client and the IICMB Wishbone slave port; replaces hand-sequenced register traffic with a hardware engine.
- Supports multiple busses, bursts up to MAX_LEN, both directions, and NAK/arbitration-loss recovery.

Parameters:
- NUM_I2C_BUSSES, 1, number of IICMB busses; legal bus IDs are 0..NUM_I2C_BUSSES-1.
- BUS_ID_WIDTH, 4, width of req_bus.
- I2C_ADDR_WIDTH, 7, slave address width.
- WB_ADDR_WIDTH, 2, Wishbone address width.
- WB_DATA_WIDTH, 8, Wishbone and I2C byte width.
- MAX_LEN, 32, maximum bytes per request.
- LEN_WIDTH, $clog2(MAX_LEN+1), width of req_len.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- req_bus_i  in  BUS_ID_WIDTH  target bus.
- req_addr_i  in  I2C_ADDR_WIDTH  slave address.
- req_rd_i  in  1  1 = read, 0 = write.
- req_len_i  in  LEN_WIDTH  byte count; 0 = address-only probe.
- wdata_valid_i / wdata_ready_o  in/out  1/1  write-byte stream handshake.
- wdata_i  in  WB_DATA_WIDTH  write byte.
- rdata_valid_o  out  1  one-cycle pulse per read byte.
- rdata_o  out  WB_DATA_WIDTH  read byte.
- done_o  out  1  one-cycle pulse at request completion.
- err_o  out  2  status, valid with done_o: 0 OK, 1 NAK, 2 ARB_LOST, 3 BAD_BUS.
- cyc_o, stb_o, we_o  out  1  Wishbone master controls.
- adr_o  out  WB_ADDR_WIDTH  Wishbone address.
- dat_o  out  WB_DATA_WIDTH  Wishbone write data.
- dat_i  in  WB_DATA_WIDTH  Wishbone read data.
- ack_i  in  1  Wishbone acknowledge.
- irq_i  in  1  IICMB interrupt.

Behaviour:
- Reset values: all outputs 0 (req_ready_o is 0 until INIT completes).
- Reset is synchronous; when asserted mid-transfer, cyc_o/stb_o drop on the same edge and the FSM returns to INIT.
- Register map: CSR=0, DPR=1, CMDR=2.
- Commands: SET_BUS=3'b110, START=3'b100, WRITE=3'b001, READ_ACK=3'b010, READ_NAK=3'b011, STOP=3'b101. Upper CMDR bits of a command write are 0.
- Wishbone cycle: one access at a time. cyc_o/stb_o assert together and hold until ack_i; they drop the cycle after ack_i. There is no timeout.
- FSM sequence:
  - INIT: write CSR=8'hC0, then IDLE.
  - IDLE: accept a request on req_valid_i && req_ready_o; latch all req_* fields.
  - BAD_BUS check: if req_bus >= NUM_I2C_BUSSES, pulse done_o with err=3 with no Wishbone traffic.
  - SETBUS: DPR<=bus, CMDR<=SET_BUS, WAIT.
  - START: CMDR<=START, WAIT.
  - ADDR: DPR<={addr,rd}, CMDR<=WRITE, WAIT.
  - Write path, per byte: wait for wdata_valid_i; wdata_ready_o pulses for 1 cycle on the DPR write; then CMDR<=WRITE, WAIT.
  - Read path, per byte: CMDR<=READ_ACK, or READ_NAK for the last byte; WAIT; read DPR; pulse rdata_valid_o with that byte.
  - STOP: CMDR<=STOP, WAIT; pulse done_o; return to IDLE.
- WAIT:
  - Block until irq_i=1, then read CMDR.
  - Status bits: DON=bit7, NAK=bit6, AL=bit5, ERR=bit4.
  - DON → return to the saved next-state.
  - NAK → issue STOP, then done_o with err=1.
  - AL or ERR → no STOP; done_o with err=2; go to IDLE.
- Length rules:
  - len=0: START, ADDR, STOP only.
  - len>MAX_LEN: saturate to MAX_LEN.
- Byte counter counts up from 0; the last byte is when count==len-1.
- wdata_valid_i low stalls the FSM with no timeout. The I2C bus is held by the core during the stall.
- Back-to-back requests: req_ready_o rises the cycle after done_o. SETBUS is always reissued, even for the same bus.

Optional Feature:
- Macro: I2C_WB_SEQ_POLL_EN.
- Defined: irq_i is ignored. WAIT re-reads CMDR repeatedly until any of bits 7:4 is set, with 2 idle cycles between reads. INIT writes CSR=8'h80 (irq disabled).
- Undefined: irq-driven WAIT as described under Behaviour.

Decomposition:
- Package i2c_wb_seq_pkg:
  - register address constants.
  - command enum i2c_cmd_t.
  - error enum seq_err_t.
  - FSM state enum.
  - CMDR status bit indices.
- Sub-module wb_xfer_engine: single Wishbone access.
  - Inputs: start, we, adr, wdat.
  - Outputs: busy, done pulse, rdat.
  - Owns cyc_o/stb_o/we_o/adr_o/dat_o.

Test Plan:
- Write: bus 0, addr 0x22, write, len 2, bytes 0x78, 0x5A → Wishbone writes in order: CSR=C0, DPR=00, CMDR=06, CMDR=04, DPR=44, CMDR=01, DPR=78, CMDR=01, DPR=5A, CMDR=01, CMDR=05. The I2C slave model captures {78, 5A}; done_o with err=0.
- Read: addr 0x22, read, len 32, slave returns 100..131 → 31 READ_ACK then 1 READ_NAK; rdata_o stream equals 100..131; DPR written with 0x45.
- NAK: slave NAKs address 0x44 → STOP issued, done_o err=1, no data CMDR writes.
- Bad bus: NUM_I2C_BUSSES=1, req_bus=3 → done_o err=3 within 2 cycles, zero Wishbone cycles.
- Stalls: wdata_valid_i held low 500 cycles mid-burst → no Wishbone activity during the stall; remaining data correct. rst_i asserted mid-write → cyc_o=0 next edge; INIT CSR write repeats.
- I2C_WB_SEQ_POLL_EN build: irq_i tied 0 → write sequence completes with the same byte stream as the write scenario; INIT writes CSR=80.
